// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the framing FSM state encoding, the add/sub mode codes and the carry majority function.
package serial_arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_bit_cell.sv
// One-bit full adder with a registered carry between serial bit slots.
// 'load' substitutes cin_init for the stored carry on the first bit of a word; 'en' low holds the carry.
module serial_bit_cell
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    input  logic cin_init,
    input  logic a,
    input  logic b,
    output logic s,
    output logic co,
    output logic ci
);

    logic carry;

    assign ci = load ? cin_init : carry;
    assign s  = a ^ b ^ ci;
    assign co = majority(a, b, ci);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= co;
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, with word framing, stall, overflow flags and a parallel result.
// Subtraction is A + ~B + 1: B is inverted per bit and the first carry-in is forced to 1.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             bit_valid,
    input  logic             a,
    input  logic             b,
    output logic             f,
    output logic             f_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             mode;
    logic [WIDTH-1:0] shreg;
    logic             fin_pend;
    logic             fin_cout;
    logic             fin_ovf;

    logic take0;
    logic take_run;
    logic consume;
    logic last;
    logic mode_eff;
    logic b_eff;
    logic bit_s;
    logic bit_co;
    logic bit_ci;

    assign take0    = start & bit_valid;
    assign take_run = bit_valid & ~start & (state == RUN);
    assign consume  = take0 | take_run;
    assign last     = take_run & (count == LAST_BIT);

    // A start bit uses the live sub input; later bits use the mode latched at start.
    assign mode_eff = take0 ? sub : mode;
    assign b_eff    = (mode_eff == MODE_SUB) ? ~b : b;
    assign busy     = (state == RUN);

    serial_bit_cell u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (consume),
        .load     (take0),
        .cin_init (sub),
        .a        (a),
        .b        (b_eff),
        .s        (bit_s),
        .co       (bit_co),
        .ci       (bit_ci)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take0) state_next = RUN;
            RUN: begin
                if (take0) begin
                    state_next = RUN;
                end else if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is published one edge after the last bit so it lines up with the next word's bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            mode     <= MODE_ADD;
            f        <= 1'b0;
            f_valid  <= 1'b0;
            fin_pend <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            f_valid  <= consume;
            fin_pend <= last;
            done     <= fin_pend;
            if (consume) begin
                f <= bit_s;
            end
            if (take0) begin
                mode  <= sub;
                count <= CNT_W'(1);
            end else if (last) begin
                count <= '0;
            end else if (take_run) begin
                count <= count + 1'b1;
            end
            if (fin_pend) begin
                sum  <= shreg;
                cout <= fin_cout;
                ovf  <= fin_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (consume) begin
            shreg <= {bit_s, shreg[WIDTH-1:1]};
        end
        if (last) begin
            fin_cout <= bit_co;
            fin_ovf  <= bit_ci ^ bit_co;
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (WIDTH=4): word-level arithmetic model with queued expectations,
// a per-cycle compare process, and hand-computed literal results for each directed case.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a = 1'b0;
    logic         b = 1'b0;
    logic         f;
    logic         f_valid;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .bit_valid (bit_valid),
        .a         (a),
        .b         (b),
        .f         (f),
        .f_valid   (f_valid),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    logic   drv_cons = 1'b0;
    logic   exp_fv = 1'b0;
    logic   f_q[$];
    res_t   r_q[$];
    logic   f_hist[$];
    int     done_cnt = 0;
    int     done_cyc[16];
    logic [W-1:0] got_sum[16];
    logic   got_cout[16];
    logic   got_ovf[16];
    logic   got_fv[16];
    int     last_start = 0;
    int     start_of[16];
    int     words_sent = 0;
    logic   exp_f;
    res_t   exp_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        exp_fv <= drv_cons & rst_n;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("f_valid", {31'd0, f_valid}, {31'd0, exp_fv});
            if (f_valid) begin
                f_hist.push_back(f);
                if (f_q.size() == 0) begin
                    check("f_valid_unexpected", {31'd0, f_valid}, 32'd0);
                end else begin
                    exp_f = f_q.pop_front();
                    check("f_bit", {31'd0, f}, {31'd0, exp_f});
                end
            end
            if (done) begin
                if (r_q.size() == 0) begin
                    check("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    exp_r = r_q.pop_front();
                    check("sum", {28'd0, sum}, {28'd0, exp_r.s});
                    check("cout", {31'd0, cout}, {31'd0, exp_r.c});
                    check("ovf", {31'd0, ovf}, {31'd0, exp_r.o});
                end
                if (done_cnt < 16) begin
                    done_cyc[done_cnt] = cyc;
                    got_sum[done_cnt]  = sum;
                    got_cout[done_cnt] = cout;
                    got_ovf[done_cnt]  = ovf;
                    got_fv[done_cnt]   = f_valid;
                end
                done_cnt++;
            end
        end
    end

    task automatic drive(input logic s, input logic v, input logic av, input logic bv,
                         input logic sb, input logic cons);
        start     = s;
        bit_valid = v;
        a         = av;
        b         = bv;
        sub       = sb;
        drv_cons  = cons;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic noise);
        for (int k = 0; k < n; k++) drive(1'b0, noise, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Sends one word; cut >= 0 stops before that bit so the caller can abort with a new start.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb,
                        input int stall_before, input int stall_len, input int cut);
        logic [W:0] full;
        int         sa;
        int         sbv;
        int         r;
        res_t       res;
        full = {1'b0, av} + {1'b0, (sb ? ~bv : bv)} + (W+1)'(sb);
        sa   = int'($signed(av));
        sbv  = int'($signed(bv));
        r    = sb ? (sa - sbv) : (sa + sbv);
        for (int i = 0; i < W; i++) begin
            if (i == cut) return;
            if (i == stall_before) begin
                for (int k = 0; k < stall_len; k++) drive(1'b1, 1'b0, ~av[i], ~bv[i], ~sb, 1'b0);
            end
            f_q.push_back(full[i]);
            drive(i == 0, 1'b1, av[i], bv[i], (i == 0) ? sb : ~sb, 1'b1);
            if (i == 0) last_start = cyc;
        end
        res.s = full[W-1:0];
        res.c = full[W];
        res.o = (r > 7) || (r < -8);
        r_q.push_back(res);
        if (words_sent < 16) start_of[words_sent] = last_start;
        words_sent++;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 40 && done_cnt < target; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_count", done_cnt, target);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_f"}, {31'd0, f}, 32'd0);
        check({tag, "_f_valid"}, {31'd0, f_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sum"}, {28'd0, sum}, 32'd0);
        check({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2, 1'b0);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2, 1'b1);

        // 5 + 6
        send(4'd5, 4'd6, 1'b0, -1, 0, -1);
        wait_done(1);
        check("add5_6_sum", {28'd0, got_sum[0]}, 32'b1011);
        check("add5_6_cout", {31'd0, got_cout[0]}, 32'd0);
        check("add5_6_ovf", {31'd0, got_ovf[0]}, 32'd1);
        check("add5_6_fbits", {28'd0, f_hist[3], f_hist[2], f_hist[1], f_hist[0]}, 32'b1011);
        check("add5_6_latency", done_cyc[0] - start_of[0], 4);
        idle(2, 1'b1);

        // 11 + 12 then 2 + 3 with zero gap
        send(4'd11, 4'd12, 1'b0, -1, 0, -1);
        send(4'd2, 4'd3, 1'b0, -1, 0, -1);
        wait_done(3);
        check("add11_12_sum", {28'd0, got_sum[1]}, 32'b0111);
        check("add11_12_cout", {31'd0, got_cout[1]}, 32'd1);
        check("add11_12_ovf", {31'd0, got_ovf[1]}, 32'd1);
        check("add2_3_sum", {28'd0, got_sum[2]}, 32'b0101);
        check("add2_3_cout", {31'd0, got_cout[2]}, 32'd0);
        check("add2_3_ovf", {31'd0, got_ovf[2]}, 32'd0);
        check("b2b_done_spacing", done_cyc[2] - done_cyc[1], 4);
        check("b2b_done_with_fvalid", {31'd0, got_fv[1]}, 32'd1);

        // 3 - 5 and 8 - 1
        send(4'd3, 4'd5, 1'b1, -1, 0, -1);
        wait_done(4);
        check("sub3_5_sum", {28'd0, got_sum[3]}, 32'b1110);
        check("sub3_5_cout", {31'd0, got_cout[3]}, 32'd0);
        check("sub3_5_ovf", {31'd0, got_ovf[3]}, 32'd0);
        send(4'd8, 4'd1, 1'b1, -1, 0, -1);
        wait_done(5);
        check("sub8_1_sum", {28'd0, got_sum[4]}, 32'b0111);
        check("sub8_1_cout", {31'd0, got_cout[4]}, 32'd1);
        check("sub8_1_ovf", {31'd0, got_ovf[4]}, 32'd1);
        idle(1, 1'b1);

        // 7 + 1 with a 3-cycle stall before bit 2
        send(4'd7, 4'd1, 1'b0, 2, 3, -1);
        wait_done(6);
        check("stall_sum", {28'd0, got_sum[5]}, 32'b1000);
        check("stall_ovf", {31'd0, got_ovf[5]}, 32'd1);
        check("stall_latency", done_cyc[5] - start_of[5], 7);
        idle(1, 1'b1);

        // 6 + 6 aborted at bit 2 by 1 + 1
        send(4'd6, 4'd6, 1'b0, -1, 0, 2);
        send(4'd1, 4'd1, 1'b0, -1, 0, -1);
        wait_done(7);
        check("abort_sum", {28'd0, got_sum[6]}, 32'b0010);
        check("abort_cout", {31'd0, got_cout[6]}, 32'd0);
        idle(3, 1'b0);
        check("abort_no_extra_done", done_cnt, 7);

        // reset mid-word
        send(4'd9, 4'd3, 1'b0, -1, 0, 2);
        rst_n    = 1'b0;
        drv_cons = 1'b0;
        exp_fv   = 1'b0;
        f_q.delete();
        idle(2, 1'b0);
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        idle(3, 1'b1);
        check_zero_outputs("post_reset");
        check("reset_no_done", done_cnt, 7);
        send(4'd4, 4'd4, 1'b0, -1, 0, -1);
        wait_done(8);
        check("add4_4_sum", {28'd0, got_sum[7]}, 32'b1000);
        check("add4_4_ovf", {31'd0, got_ovf[7]}, 32'd1);
        check("add4_4_cout", {31'd0, got_cout[7]}, 32'd0);
        idle(3, 1'b0);

        check("f_queue_drained", f_q.size(), 0);
        check("result_queue_drained", r_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
